id_ex_operand_stage: RTL

- Parametrised successor to the single-cycle datapath select muxes (destination-register select, ALU operand-B select).
- Adds EX/MEM and MEM/WB operand forwarding, a link-register destination and a shift-amount operand.
- Outputs are registered as the ID/EX pipeline register, with stall and flush control.
- Sits between decode/register-file read and the ALU in the pipelined core.

---
 rtl/id_ex_operand_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID/EX pipeline register with EX/MEM and MEM/WB operand
//               forwarding, destination and ALU operand-B selection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int W        = 32,
    parameter int RA       = 5,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [RA-1:0] rs,
    input  logic [RA-1:0] rt,
    input  logic [RA-1:0] rd,
    input  logic [W-1:0]  bus_a,
    input  logic [W-1:0]  bus_b,
    input  logic [W-1:0]  imm,
    input  logic [4:0]    shamt,
    input  logic [1:0]    reg_dst,
    input  logic [1:0]    alu_src,
    input  logic          mem_to_reg,
    input  logic          reg_write,
    input  logic          exm_reg_write,
    input  logic          mwb_reg_write,
    input  logic [RA-1:0] exm_rw,
    input  logic [RA-1:0] mwb_rw,
    input  logic [W-1:0]  exm_data,
    input  logic [W-1:0]  mwb_data,
    output logic          out_valid,
    output logic [W-1:0]  out_alu_a,
    output logic [W-1:0]  out_alu_b,
    output logic [W-1:0]  out_store_data,
    output logic [RA-1:0] out_rw,
    output logic          out_mem_to_reg,
    output logic          out_reg_write,
    output logic [1:0]    out_fwd_a,
    output logic [1:0]    out_fwd_b
);

    localparam logic [RA-1:0] c_LINK    = RA'(LINK_REG);
    localparam logic [1:0]    c_FWD_RF  = 2'b00;
    localparam logic [1:0]    c_FWD_EXM = 2'b01;
    localparam logic [1:0]    c_FWD_MWB = 2'b10;

    logic [1:0]    w_fwdA;
    logic [1:0]    w_fwdB;
    logic [W-1:0]  w_fa;
    logic [W-1:0]  w_fb;
    logic [W-1:0]  w_aluB;
    logic [RA-1:0] w_rw;
    logic          w_effRegWrite;

    logic          r_valid;
    logic [W-1:0]  r_aluA;
    logic [W-1:0]  r_aluB;
    logic [W-1:0]  r_storeData;
    logic [RA-1:0] r_rw;
    logic          r_memToReg;
    logic          r_regWrite;
    logic [1:0]    r_fwdA;
    logic [1:0]    r_fwdB;

    // EX/MEM is the younger producer, so it is checked first; r0 never forwards.
    always_comb begin
        w_fwdA = c_FWD_RF;
        w_fa   = bus_a;
        if (rs != '0 && exm_reg_write && exm_rw == rs) begin
            w_fwdA = c_FWD_EXM;
            w_fa   = exm_data;
        end else if (rs != '0 && mwb_reg_write && mwb_rw == rs) begin
            w_fwdA = c_FWD_MWB;
            w_fa   = mwb_data;
        end

        w_fwdB = c_FWD_RF;
        w_fb   = bus_b;
        if (rt != '0 && exm_reg_write && exm_rw == rt) begin
            w_fwdB = c_FWD_EXM;
            w_fb   = exm_data;
        end else if (rt != '0 && mwb_reg_write && mwb_rw == rt) begin
            w_fwdB = c_FWD_MWB;
            w_fb   = mwb_data;
        end

        case (alu_src)
            2'b01:   w_aluB = imm;
            2'b10:   w_aluB = {{(W-5){1'b0}}, shamt};
            default: w_aluB = w_fb;
        endcase

        case (reg_dst)
            2'b01:   w_rw = rd;
            2'b10:   w_rw = c_LINK;
            default: w_rw = rt;
        endcase

        w_effRegWrite = in_valid & reg_write & (w_rw != '0);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid     <= 1'b0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_storeData <= '0;
            r_rw        <= '0;
            r_memToReg  <= 1'b0;
            r_regWrite  <= 1'b0;
            r_fwdA      <= c_FWD_RF;
            r_fwdB      <= c_FWD_RF;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_fwdA     <= w_fwdA;
            r_fwdB     <= w_fwdB;
            r_memToReg <= in_valid & mem_to_reg;
            r_regWrite <= w_effRegWrite;
            // Bubbles carry no data so downstream never sees stale operands.
            if (in_valid) begin
                r_aluA      <= w_fa;
                r_aluB      <= w_aluB;
                r_storeData <= w_fb;
                r_rw        <= w_rw;
            end else begin
                r_aluA      <= '0;
                r_aluB      <= '0;
                r_storeData <= '0;
                r_rw        <= '0;
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_alu_a      = r_aluA;
    assign out_alu_b      = r_aluB;
    assign out_store_data = r_storeData;
    assign out_rw         = r_rw;
    assign out_mem_to_reg = r_memToReg;
    assign out_reg_write  = r_regWrite;
    assign out_fwd_a      = r_fwdA;
    assign out_fwd_b      = r_fwdB;

endmodule
`default_nettype wire
